bin2res_mod5_seq: RTL and testbench

//  Bit-serial binary-to-residue converter for the mod-5 channel of the RNS datapath.

---
 rtl/rns_pkg.sv | 22 ++
 rtl/bin2res_mod5_seq_lut.sv | 23 ++
 rtl/bin2res_mod5_seq.sv | 87 ++++++++
 tb/tb_bin2res_mod5_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared types and constants for the RNS mod-5 channel.
package rns_pkg;

  localparam logic [2:0]  MOD5      = 3'd5;
  localparam int unsigned LUT_IN_W  = 32;
  localparam int unsigned LUT_DEPTH = 32;
  localparam int unsigned SUM_W     = 4;

  typedef logic [2:0] res5_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fold a partial sum in 0..8 back into the residue range 0..4.
  function automatic res5_t mod5_reduce(input logic [SUM_W-1:0] s);
    return (s >= SUM_W'(MOD5)) ? res5_t'(s - SUM_W'(MOD5)) : res5_t'(s);
  endfunction

endpackage

// File: rtl/bin2res_mod5_seq_lut.sv
// Weight table: 2^i mod 5 for bit positions i = 0..31, zero outside the table.
module mod5_LUT
  import rns_pkg::*;
(
  input  logic [LUT_IN_W-1:0] idx,
  output res5_t               weight_c
);

  // 2^i mod 5 repeats with period 4: 1, 2, 4, 3.
  always_comb begin
    weight_c = '0;
    if (idx < LUT_IN_W'(LUT_DEPTH)) begin
      case (idx[1:0])
        2'd0: weight_c = 3'd1;
        2'd1: weight_c = 3'd2;
        2'd2: weight_c = 3'd4;
        2'd3: weight_c = 3'd3;
        default: weight_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/bin2res_mod5_seq.sv
// Bit-serial binary-to-residue converter: returns in_data mod 5, one bit per clock.
module bin2res_mod5_seq
  import rns_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output res5_t            out_res
);

  if (WIDTH < 2 || WIDTH > LUT_DEPTH || (2 ** IDX_W) < WIDTH) begin : g_param_check
    $error("bin2res_mod5_seq: illegal WIDTH/IDX_W combination");
  end

  state_t              state, state_next;
  logic [WIDTH-1:0]    sh, sh_next;
  logic [IDX_W-1:0]    idx, idx_next;
  res5_t               acc, acc_next;
  res5_t               weight_c;
  logic [SUM_W-1:0]    sum;

  mod5_LUT u_lut (
    .idx      (LUT_IN_W'(idx)),
    .weight_c (weight_c)
  );

  assign in_ready = (state == IDLE);

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    sh_next    = sh;
    idx_next   = idx;
    acc_next   = acc;
    sum        = SUM_W'(acc) + (sh[0] ? SUM_W'(weight_c) : SUM_W'(0));
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = BUSY;
          sh_next    = in_data;
          idx_next   = '0;
          acc_next   = '0;
        end
      end
      BUSY: begin
        acc_next = mod5_reduce(sum);
        sh_next  = sh >> 1;
        idx_next = idx + IDX_W'(1);
        if (idx == IDX_W'(WIDTH - 1)) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output flops mirror the DONE state so the residue is held under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
    end else begin
      state     <= state_next;
      sh        <= sh_next;
      idx       <= idx_next;
      acc       <= acc_next;
      out_valid <= (state_next == DONE);
      out_res   <= (state_next == DONE) ? acc_next : '0;
    end
  end

  a_acc_range: assert property (@(posedge clk) disable iff (!rst_n) acc < MOD5);
  a_res_zero:  assert property (@(posedge clk) disable iff (!rst_n) !out_valid |-> out_res == '0);

endmodule

// File: tb/tb_bin2res_mod5_seq.sv
// Randomized self-checking bench for bin2res_mod5_seq against an X % 5 model.
module tb_bin2res_mod5_seq;

  localparam int unsigned WIDTH   = 32;
  localparam int          N_RAND  = 1500;
  localparam int          BOUND   = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_res;

  int total  = 0;
  int passed = 0;

  bin2res_mod5_seq #(.WIDTH(WIDTH), .IDX_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", passed, total);
    $fatal(1);
  end

  function automatic logic [2:0] ref_mod5(input logic [31:0] x);
    logic [31:0] r;
    r = x % 32'd5;
    return r[2:0];
  endfunction

  task automatic send_op(input logic [31:0] x);
    int n;
    n = 0;
    in_data  = x;
    in_valid = 1'b1;
    while (!in_ready && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom();
  endtask

  task automatic wait_result(output int lat, output bit rdy_seen);
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < BOUND) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #3;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (out_res !== 3'd0) $display("FAIL reset_out_res got=%0d exp=0", out_res); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] vals [6];
    int lat;
    bit rdy;
    vals = '{32'd0, 32'd7, 32'd1234567, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 6; i++) begin
      send_op(vals[i]);
      wait_result(lat, rdy);
      total++; if (lat != WIDTH) $display("FAIL dir_latency x=%h got=%0d exp=%0d", vals[i], lat, WIDTH); else passed++;
      total++; if (rdy !== 1'b0) $display("FAIL dir_in_ready_busy x=%h got=%b exp=0", vals[i], rdy); else passed++;
      total++; if (out_res !== ref_mod5(vals[i])) $display("FAIL dir_res x=%h got=%0d exp=%0d", vals[i], out_res, ref_mod5(vals[i])); else passed++;
      release_result();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_res !== 3'd0)
        $display("FAIL dir_after_hs x=%h got v=%b r=%b res=%0d exp v=0 r=1 res=0", vals[i], out_valid, in_ready, out_res);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x;
    logic [2:0]  exp;
    int lat;
    bit rdy;
    x = $urandom();
    exp = ref_mod5(x);
    send_op(x);
    wait_result(lat, rdy);
    total++; if (lat != WIDTH) $display("FAIL bp_latency got=%0d exp=%0d", lat, WIDTH); else passed++;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom() % 2);
      in_data  = $urandom();
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_res !== exp || in_ready !== 1'b0)
        $display("FAIL bp_hold cyc=%0d got v=%b res=%0d r=%b exp v=1 res=%0d r=0", c, out_valid, out_res, in_ready, exp);
      else passed++;
    end
    in_valid = 1'b0;
    release_result();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid); else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_no_capture got r=%b v=%b exp r=1 v=0", in_ready, out_valid); else passed++;
  endtask

  task automatic test_reset_abort();
    int lat;
    bit rdy;
    send_op($urandom());
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL abort_busy got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    send_op($urandom());
    wait_result(lat, rdy);
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_res !== 3'd0) $display("FAIL abort_done got v=%b res=%0d exp v=0 res=0", out_valid, out_res); else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    send_op(32'd13);
    wait_result(lat, rdy);
    total++; if (lat != WIDTH) $display("FAIL abort_new_latency got=%0d exp=%0d", lat, WIDTH); else passed++;
    total++; if (out_res !== 3'd3) $display("FAIL abort_new_res got=%0d exp=3", out_res); else passed++;
    release_result();
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [2:0]  exp;
    int lat, guard;
    bit rdy, done, r;
    for (int k = 0; k < N_RAND; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      x = $urandom();
      if (k % 8 == 0) x = x & 32'hFFFF_0000;
      exp = ref_mod5(x);
      send_op(x);
      wait_result(lat, rdy);
      total++; if (lat != WIDTH || rdy !== 1'b0) $display("FAIL rnd_latency k=%0d got lat=%0d rdy=%b exp lat=%0d rdy=0", k, lat, rdy, WIDTH); else passed++;
      total++; if (out_res !== exp) $display("FAIL rnd_res k=%0d x=%h got=%0d exp=%0d", k, x, out_res, exp); else passed++;
      done = 1'b0;
      guard = 0;
      while (!done && guard < 50) begin
        r = 1'($urandom() % 2);
        out_ready = r;
        in_valid  = 1'($urandom() % 2);
        @(posedge clk); #1;
        guard++;
        if (r) done = 1'b1;
        else begin
          total++; if (out_valid !== 1'b1 || out_res !== exp)
            $display("FAIL rnd_stable k=%0d got v=%b res=%0d exp v=1 res=%0d", k, out_valid, out_res, exp);
          else passed++;
        end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rnd_handshake k=%0d got v=%b r=%b exp v=0 r=1", k, out_valid, in_ready); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
